// File: rtl/call_stack_pkg.sv
// Shared constants and types for the return-address stack and its PC-stage neighbour.
package call_stack_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam int unsigned STACK_DEPTH = 16;
  localparam int unsigned STACK_WIDTH = 32;

  typedef enum logic [1:0] {
    PC_INC    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_STACK  = 2'b10,
    PC_HOLD   = 2'b11
  } pcsrc_e;

  // Encoded as {push, pop} so the request pair casts straight onto it.
  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

endpackage

// File: rtl/call_stack_if.sv
// Request/response bundle between the CALL/RET control and the return-address stack.
interface call_stack_if #(
  parameter int unsigned WIDTH = 32
);
  logic             EN;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] top;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output EN, push, pop, push_data,
    input  top, empty, full, overflow, underflow
  );

  modport slave (
    input  EN, push, pop, push_data,
    output top, empty, full, overflow, underflow
  );
endinterface

// File: rtl/call_stack_mem.sv
// stack_mem: DEPTH x WIDTH register array, one synchronous write port, one async read port.
module stack_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/call_stack.sv
// Return-address stack for CALL/RET feeding the PC stage's topStack input.
// Define CALL_STACK_ERR_EN to get sticky overflow/underflow flags; otherwise they read 0.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int unsigned WIDTH = STACK_WIDTH,
  parameter int unsigned DEPTH = STACK_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH) + 1
) (
  input  logic         clock,
  input  logic         reset,
  call_stack_if.slave  stk
);

  localparam int unsigned AW = PTR_W - 1;

  logic [PTR_W-1:0] sp_q, sp_d;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;
  logic             is_empty, is_full;
  logic             ovf_set, unf_set;
  stack_op_e        op;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == PTR_W'(DEPTH));
  assign raddr    = AW'(sp_q - 1'b1);
  assign op       = stack_op_e'({stk.push, stk.pop});

  always_comb begin
    sp_d    = sp_q;
    we      = 1'b0;
    waddr   = AW'(sp_q);
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (stk.EN) begin
      unique case (op)
        OP_PUSH: begin
          if (!is_full) begin
            we   = 1'b1;
            sp_d = sp_q + 1'b1;
          end else begin
            ovf_set = 1'b1;
          end
        end
        OP_POP: begin
          if (!is_empty) sp_d = sp_q - 1'b1;
          else           unf_set = 1'b1;
        end
        OP_REPLACE: begin
          // Tail-call overwrites the top in place; on an empty stack it degrades to a push.
          we = 1'b1;
          if (!is_empty) begin
            waddr = raddr;
          end else begin
            sp_d    = sp_q + 1'b1;
            unf_set = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) sp_q <= '0;
    else       sp_q <= sp_d;
  end

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock (clock),
    .we    (we && !reset),
    .waddr (waddr),
    .wdata (stk.push_data),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign stk.top   = is_empty ? '0 : rdata;
  assign stk.empty = is_empty;
  assign stk.full  = is_full;

`ifdef CALL_STACK_ERR_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ovf_set;
      unf_q <= unf_q | unf_set;
    end
  end

  assign stk.overflow  = ovf_q;
  assign stk.underflow = unf_q;
`else
  logic err_unused;
  assign err_unused    = ovf_set | unf_set;
  assign stk.overflow  = LOW;
  assign stk.underflow = LOW;
`endif

endmodule
